// File: rtl/p_sched_pkg.sv
// Shared types and helpers for the piston port arbiter.
// Control-field offsets are counted down from the top of k_ctrl.
package p_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // k_ctrl[SELOU-CTRL_LAST] is last, k_ctrl[SELOU-CTRL_FORCED] is forced_close
    localparam int CTRL_LAST   = 1;
    localparam int CTRL_FORCED = 2;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/p_rr_pick.sv
// Rotating-priority picker: first set bit of valid at or after ptr.
// Purely combinational; sel is one-hot or zero.
import p_sched_pkg::*;

module p_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          any
);

    // scan from the farthest slot back to ptr so the nearest valid wins
    always_comb begin
        int j;
        j   = 0;
        sel = '0;
        idx = '0;
        any = |valid;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (valid[j]) idx = IW'(j);
        end
        if (any) sel[idx] = 1'b1;
    end

endmodule

// File: rtl/p_encode_arb.sv
// Round-robin burst-locked arbiter onto one piston data port.
// Winning beats are packed as {k_ctrl, data} into a valid/ready register.
import p_sched_pkg::*;

module p_encode_arb #(
    parameter int NREQ      = 4,
    parameter int SLICES    = 4,
    parameter int PERIN     = 8,
    parameter int SELOU     = 4,
    parameter int MAX_BURST = 16,
    localparam int DW       = SLICES * PERIN,
    localparam int IDW      = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ*DW-1:0]    req_dat,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    output logic [SELOU+DW-1:0]   t_kp_dat,
    output logic                  t_kp_valid,
    input  logic                  t_kp_ready,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id
);

    localparam int CW = $clog2(MAX_BURST + 1);

    generate
        if (SELOU < IDW + 2) begin : g_selou_chk
            $error("SELOU too narrow for id, last and forced_close");
        end
        if (MAX_BURST < 1) begin : g_burst_chk
            $error("MAX_BURST must be at least 1");
        end
    endgenerate

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    logic            load_en;
    logic [NREQ-1:0] pk_sel;
    logic [IDW-1:0]  pk_idx;
    logic            pk_any;

    logic            acc;
    logic [IDW-1:0]  src;
    logic [IDW-1:0]  src_inc;
    logic            beat_last;
    logic            hit;
    logic            rel;
    logic            forced;
    logic [SELOU-1:0] ctrl;
    logic [DW-1:0]   src_dat;

    assign load_en = !t_kp_valid || t_kp_ready;
    assign busy    = (state == BURST);

    p_rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .sel   (pk_sel),
        .idx   (pk_idx),
        .any   (pk_any)
    );

    // grant selection, acceptance, release decision and k_ctrl packing
    always_comb begin
        req_ready = '0;
        acc       = 1'b0;
        src       = grant_id;
        state_nxt = state;
        if (reset_n) begin
            unique case (state)
                IDLE: begin
                    if (load_en && pk_any) begin
                        req_ready = pk_sel;
                        acc       = 1'b1;
                        src       = pk_idx;
                    end
                end
                BURST: begin
                    req_ready[grant_id] = load_en;
                    acc = load_en && req_valid[grant_id];
                end
            endcase
        end
        cnt_nxt   = (state == BURST) ? cnt + 1'b1 : CW'(1);
        hit       = (cnt_nxt == CW'(MAX_BURST));
        beat_last = req_last[src];
        rel       = beat_last || hit;
        forced    = hit && !beat_last;
        src_inc   = (int'(src) == NREQ - 1) ? '0 : src + 1'b1;
        src_dat   = req_dat[int'(src)*DW +: DW];
        ctrl      = '0;
        ctrl[IDW-1:0]               = src;
        ctrl[SELOU - CTRL_LAST]     = rel;
        ctrl[SELOU - CTRL_FORCED]   = forced;
        if (acc) state_nxt = rel ? IDLE : BURST;
    end

    // FSM, grant bookkeeping and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            grant_id   <= '0;
            t_kp_dat   <= '0;
            t_kp_valid <= 1'b0;
        end else begin
            if (acc) begin
                state    <= state_nxt;
                grant_id <= src;
                cnt      <= cnt_nxt;
                if (rel) rr_ptr <= src_inc;
            end
            if (load_en) begin
                t_kp_valid <= acc;
                if (acc) t_kp_dat <= {ctrl, src_dat};
            end
        end
    end

endmodule

// File: tb/tb_p_encode_arb.sv
// Bench for p_encode_arb: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural arbitration model.
module tb_p_encode_arb;

    localparam int NREQ      = 4;
    localparam int SLICES    = 4;
    localparam int PERIN     = 8;
    localparam int SELOU     = 4;
    localparam int MAX_BURST = 16;
    localparam int DW        = SLICES * PERIN;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ*DW-1:0]   req_dat;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [SELOU+DW-1:0]  t_kp_dat;
    logic                 t_kp_valid;
    logic                 t_kp_ready;
    logic                 busy;
    logic [1:0]           grant_id;

    p_encode_arb #(
        .NREQ      (NREQ),
        .SLICES    (SLICES),
        .PERIN     (PERIN),
        .SELOU     (SELOU),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_dat    (req_dat),
        .req_last   (req_last),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .t_kp_dat   (t_kp_dat),
        .t_kp_valid (t_kp_valid),
        .t_kp_ready (t_kp_ready),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: grant owner, rotation point, beats in grant, output reg
    bit          m_busy;
    int          m_gid;
    int          m_ptr;
    int          m_cnt;
    bit          m_oval;
    logic [35:0] m_odat;
    logic [NREQ-1:0] acc_s;

    function automatic int m_pick();
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] m_ready();
        int w;
        if (m_oval && !t_kp_ready) return '0;
        if (m_busy) return NREQ'(1 << m_gid);
        w = m_pick();
        if (w < 0) return '0;
        return NREQ'(1 << w);
    endfunction

    task automatic m_step();
        int  id;
        int  c;
        bit  hitb;
        bit  lst;
        bit  fin;
        logic [1:0] id2;
        if (m_oval && !t_kp_ready) return;
        if (m_busy) id = req_valid[m_gid] ? m_gid : -1;
        else        id = m_pick();
        if (id < 0) begin
            m_oval = 0;
            return;
        end
        c    = m_busy ? m_cnt + 1 : 1;
        hitb = (c >= MAX_BURST);
        lst  = req_last[id];
        fin  = lst || hitb;
        id2  = 2'(id);
        m_odat = {fin, hitb && !lst, id2, req_dat[id*DW +: DW]};
        m_oval = 1;
        m_gid  = id;
        m_cnt  = c;
        if (fin) begin
            m_busy = 0;
            m_ptr  = (id + 1) % NREQ;
        end else begin
            m_busy = 1;
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_gid = 0; m_ptr = 0; m_cnt = 0;
        m_oval = 0; m_odat = '0;
    endtask

    // called just after a negedge with inputs already driven
    task automatic step();
        #1;
        check("ready", 64'(req_ready), 64'(m_ready()));
        check("valid", 64'(t_kp_valid), 64'(m_oval));
        check("dat", 64'(t_kp_dat), 64'(m_odat));
        check("busy", 64'(busy), 64'(m_busy));
        check("gid", 64'(grant_id), 64'(m_gid));
        acc_s = req_ready & req_valid;
        m_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid", 64'(t_kp_valid), 64'd0);
        check("rst_dat", 64'(t_kp_dat), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_gid", 64'(grant_id), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        m_reset();
        acc_s = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic new_beat(input int i, input int lastp);
        req_dat[i*DW +: DW] = $urandom;
        req_last[i] = ($urandom_range(99) < lastp);
    endtask

    logic [35:0] held;

    initial begin
        reset_n    = 1'b1;
        req_dat    = '0;
        req_last   = '0;
        req_valid  = '0;
        t_kp_ready = 1'b1;
        acc_s      = '0;
        m_reset();
        @(negedge clk);
        do_reset();

        // single beat from requester 2
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        req_dat[2*DW +: DW] = 32'hCAFEF00D;
        #1 check("t1_ready", 64'(req_ready), 64'h4);
        step();
        req_valid = '0;
        check("t1_dat", 64'(t_kp_dat), 64'hA_CAFEF00D);
        check("t1_valid", 64'(t_kp_valid), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        step();

        // all requesters with single-beat bursts rotate 0,1,2,3,0
        do_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 check("t2_order", 64'(req_ready), 64'(1 << (k % 4)));
            step();
        end

        // three-beat burst from 1 while 0 stays valid
        req_valid = 4'b0011;
        req_last  = 4'b0001;
        req_dat[1*DW +: DW] = 32'h1111_0001;
        #1 check("t3_first", 64'(req_ready), 64'h2);
        step();
        check("t3_b1", 64'(t_kp_dat[35:32]), 64'h1);
        req_dat[1*DW +: DW] = 32'h1111_0002;
        step();
        check("t3_b2", 64'(t_kp_dat[35:32]), 64'h1);
        req_last[1] = 1'b1;
        req_dat[1*DW +: DW] = 32'h1111_0003;
        step();
        check("t3_b3", 64'(t_kp_dat), 64'h9_1111_0003);
        #1 check("t3_next", 64'(req_ready), 64'h1);
        step();

        // requester 3 streams with no last: forced close at beat 16
        do_reset();
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        step();
        req_valid = 4'b1001;
        req_last  = 4'b0001;
        for (int k = 2; k <= 16; k++) begin
            req_dat[3*DW +: DW] = 32'(k);
            step();
        end
        check("t4_forced", 64'(t_kp_dat[35:32]), 64'hF);
        check("t4_data", 64'(t_kp_dat[31:0]), 64'd16);
        #1 check("t4_pass", 64'(req_ready), 64'h1);
        for (int k = 0; k < 4; k++) step();

        // downstream stall mid-burst
        do_reset();
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            req_dat[1*DW +: DW] = 32'hB000_0000 + 32'(k);
            step();
        end
        t_kp_ready = 1'b0;
        held = t_kp_dat;
        for (int k = 0; k < 5; k++) begin
            req_dat[1*DW +: DW] = 32'hC000_0000 + 32'(k);
            step();
            check("t5_hold", 64'(t_kp_dat), 64'(held));
            check("t5_noready", 64'(req_ready), 64'd0);
        end
        t_kp_ready = 1'b1;
        req_last[1] = 1'b1;
        step();
        check("t5_resume", 64'(t_kp_dat), 64'h9_C000_0004);
        req_valid = '0;
        step();

        // reset mid-burst, then rotation restarts at requester 0
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        step();
        step();
        do_reset();
        req_valid = 4'b1111;
        #1 check("t6_restart", 64'(req_ready), 64'h1);
        step();

        // random traffic with stalls and occasional resets
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) new_beat(i, 30);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int lastp;
            lastp = (cyc / 500) % 2 ? 3 : 35;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_s[i]) begin
                    req_valid[i] = ($urandom_range(3) != 0);
                    new_beat(i, lastp);
                end else if (!req_valid[i]) begin
                    req_valid[i] = ($urandom_range(9) < 6);
                end
            end
            t_kp_ready = ($urandom_range(3) != 0);
            if (cyc % 700 == 350) do_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
